// File: rtl/zap_ifetch_pkg.sv
// Shared types and constants for the ZAP instruction-fetch Wishbone master.
package zap_ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDrain
  } fetch_state_e;

  localparam logic [2:0] CTI_EOB    = 3'b111;
  localparam logic [1:0] BTE_LINEAR = 2'b00;

  // Push-word layout {abort, pc, instr}; the fixed offsets assume AW = DW = 32.
  localparam int unsigned INSTR_LSB = 0;
  localparam int unsigned PC_LSB    = 32;
  localparam int unsigned ABORT_BIT = 64;

  function automatic int unsigned pc_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned abort_bit(input int unsigned aw, input int unsigned dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/zap_ifetch_wb_master.sv
// Wishbone B3 classic single-beat instruction fetch master feeding the prefetch FIFO.
// Redirects during a transfer drain the bus cycle and drop the stale instruction.
module zap_ifetch_wb_master
  import zap_ifetch_pkg::*;
#(
  parameter int unsigned  AW       = 32,
  parameter int unsigned  DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_redirect,
  input  logic [AW-1:0]     i_redirect_pc,
  input  logic              i_fifo_not_full,
  output logic              o_wb_cyc,
  output logic              o_wb_stb,
  output logic              o_wb_we,
  output logic [DW/8-1:0]   o_wb_sel,
  output logic [AW-1:0]     o_wb_adr,
  output logic [2:0]        o_wb_cti,
  output logic [1:0]        o_wb_bte,
  input  logic              i_wb_ack,
  input  logic              i_wb_err,
  input  logic [DW-1:0]     i_wb_dat,
  output logic              o_push_valid,
  output logic [AW+DW:0]    o_push_data
);

  localparam int unsigned   PcLsb    = pc_lsb(DW);
  localparam int unsigned   AbortBit = abort_bit(AW, DW);
  localparam logic [AW-1:0] PcStep   = AW'(4);
  localparam logic [AW-1:0] WordMask = ~AW'(3);

  fetch_state_e    state_q;
  logic [AW-1:0]   pc_q;
  logic            term;

  assign term = i_wb_ack | i_wb_err;

  assign o_wb_we  = 1'b0;
  assign o_wb_sel = '1;
  assign o_wb_cti = CTI_EOB;
  assign o_wb_bte = BTE_LINEAR;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      o_wb_cyc     <= 1'b0;
      o_wb_stb     <= 1'b0;
      o_wb_adr     <= RESET_PC;
      o_push_valid <= 1'b0;
      o_push_data  <= '0;
    end else begin
      o_push_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (i_redirect) begin
            pc_q <= i_redirect_pc & WordMask;
          end else if (i_fifo_not_full) begin
            o_wb_cyc <= 1'b1;
            o_wb_stb <= 1'b1;
            o_wb_adr <= pc_q;
            state_q  <= StReq;
          end
        end
        StReq: begin
          if (term) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            state_q  <= StIdle;
            if (i_redirect) begin
              // Redirect wins over the returning word: it belongs to the old stream.
              pc_q <= i_redirect_pc & WordMask;
            end else begin
              o_push_valid                  <= 1'b1;
              o_push_data[AbortBit]         <= i_wb_err;
              o_push_data[PcLsb +: AW]      <= o_wb_adr;
              o_push_data[DW-1:0]           <= i_wb_err ? '0 : i_wb_dat;
              pc_q                          <= o_wb_adr + PcStep;
            end
          end else if (i_redirect) begin
            pc_q    <= i_redirect_pc & WordMask;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (i_redirect) begin
            pc_q <= i_redirect_pc & WordMask;
          end
          if (term) begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  a_stb_implies_cyc: assert property (@(posedge i_clk) disable iff (i_reset)
    o_wb_stb |-> o_wb_cyc);

  a_adr_stable: assert property (@(posedge i_clk) disable iff (i_reset)
    (o_wb_stb && !i_wb_ack && !i_wb_err) |=> $stable(o_wb_adr));

  a_push_single: assert property (@(posedge i_clk) disable iff (i_reset)
    o_push_valid |=> !o_push_valid);

endmodule

// File: tb/tb_zap_ifetch_wb_master.sv
// Directed bench for zap_ifetch_wb_master: expected requests and pushes are queued by the
// stimulus and checked by a negedge monitor.
module tb_zap_ifetch_wb_master;

  localparam logic [31:0] INSTR = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        reset, redirect, fifo_not_full;
  logic [31:0] redirect_pc;
  logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr, wb_dat;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic        push_valid;
  logic [64:0] push_data;

  // Slave model state
  logic [31:0] wait_adr = 32'h1;
  logic [31:0] err_adr  = 32'h1;
  int          cnt      = 0;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_req[$];
  logic [64:0] exp_push[$];
  logic        stb_q = 1'b0;

  always #5 clk = ~clk;

  zap_ifetch_wb_master #(.AW(32), .DW(32), .RESET_PC(32'h0)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_redirect      (redirect),
    .i_redirect_pc   (redirect_pc),
    .i_fifo_not_full (fifo_not_full),
    .o_wb_cyc        (wb_cyc),
    .o_wb_stb        (wb_stb),
    .o_wb_we         (wb_we),
    .o_wb_sel        (wb_sel),
    .o_wb_adr        (wb_adr),
    .o_wb_cti        (wb_cti),
    .o_wb_bte        (wb_bte),
    .i_wb_ack        (wb_ack),
    .i_wb_err        (wb_err),
    .i_wb_dat        (wb_dat),
    .o_push_valid    (push_valid),
    .o_push_data     (push_data)
  );

  // Slave: 3 wait states at wait_adr, zero elsewhere; err instead of ack at err_adr.
  assign done   = wb_cyc && wb_stb && (cnt == ((wb_adr == wait_adr) ? 3 : 0));
  assign wb_ack = done && (wb_adr != err_adr);
  assign wb_err = done && (wb_adr == err_adr);
  assign wb_dat = INSTR;

  always @(posedge clk) begin
    if (wb_cyc && wb_stb && !done) cnt <= cnt + 1;
    else                           cnt <= 0;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Monitor: new requests (stb rising) and FIFO pushes against the scoreboard.
  always @(negedge clk) begin
    if (wb_stb && !stb_q) begin
      check("req_attrs", {wb_we, wb_sel, wb_cti, wb_bte, wb_adr[1:0]},
            {1'b0, 4'hF, 3'b111, 2'b00, 2'b00});
      if (exp_req.size() == 0) timeout("unexpected_req");
      else check("req_adr", wb_adr, exp_req.pop_front());
    end
    if (push_valid) begin
      if (exp_push.size() == 0) timeout("unexpected_push");
      else check("push_data", push_data, exp_push.pop_front());
    end
    stb_q = wb_stb;
  end

  task automatic wait_stb();
    int n = 0;
    while (!wb_stb && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!wb_stb) timeout("wait_stb");
  endtask

  task automatic wait_push();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!push_valid && n < 20);
    if (!push_valid) timeout("wait_push");
  endtask

  // Load the PC through an idle-state redirect with the FIFO reporting full.
  task automatic set_pc(input logic [31:0] a);
    fifo_not_full = 1'b0;
    redirect      = 1'b1;
    redirect_pc   = a;
    @(negedge clk);
    redirect      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    time t1, t2, t3;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; fifo_not_full = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_bus", {wb_cyc, wb_stb, wb_adr}, {1'b0, 1'b0, 32'h0});
    check("reset_push", {push_valid, push_data}, 66'h0);

    // Back-to-back fetches from RESET_PC with a zero-wait slave
    exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
    exp_push.push_back({1'b0, 32'h0, INSTR});
    exp_push.push_back({1'b0, 32'h4, INSTR});
    exp_push.push_back({1'b0, 32'h8, INSTR});
    reset = 1'b0;
    @(negedge clk);
    check("first_stb", {wb_stb, wb_cyc, wb_adr}, {1'b1, 1'b1, 32'h0});
    wait_push(); t1 = $time;
    wait_push(); t2 = $time;
    wait_push(); t3 = $time;
    fifo_not_full = 1'b0;
    check("push_gap_1", 64'(t2 - t1), 64'd20);
    check("push_gap_2", 64'(t3 - t2), 64'd20);
    repeat (3) @(negedge clk);
    check("idle_when_full", wb_cyc, 1'b0);

    // FIFO full from reset: no bus activity until space appears
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("full_no_cyc", wb_cyc, 1'b0);
    end
    exp_req.push_back(32'h0);
    exp_push.push_back({1'b0, 32'h0, INSTR});
    fifo_not_full = 1'b1;
    @(negedge clk);
    check("start_after_space", {wb_stb, wb_adr}, {1'b1, 32'h0});
    wait_push();
    fifo_not_full = 1'b0;
    @(negedge clk);

    // Redirect during a wait-stated transfer: drain, drop data, refetch at new PC
    wait_adr = 32'h10;
    set_pc(32'h10);
    exp_req.push_back(32'h10); exp_req.push_back(32'h200);
    exp_push.push_back({1'b0, 32'h200, INSTR});
    fifo_not_full = 1'b1;
    wait_stb();
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    check("drain_hold_1", {wb_cyc, wb_stb, wb_adr}, {1'b1, 1'b1, 32'h10});
    @(negedge clk);
    check("drain_hold_2", {wb_cyc, push_valid}, {1'b1, 1'b0});
    @(negedge clk);
    check("drain_done", {wb_cyc, push_valid}, {1'b0, 1'b0});
    wait_push();
    fifo_not_full = 1'b0;
    @(negedge clk);

    // Redirect coincident with ack: no push, next request at redirect target
    set_pc(32'h20);
    exp_req.push_back(32'h20); exp_req.push_back(32'h80);
    exp_push.push_back({1'b0, 32'h80, INSTR});
    fifo_not_full = 1'b1;
    wait_stb();
    redirect = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    redirect = 1'b0;
    check("ack_redirect_nopush", {push_valid, wb_cyc}, {1'b0, 1'b0});
    wait_push();
    fifo_not_full = 1'b0;
    @(negedge clk);

    // Bus error: abort pushed with zero instruction, PC still advances
    err_adr = 32'h40;
    set_pc(32'h40);
    exp_req.push_back(32'h40); exp_req.push_back(32'h44);
    exp_push.push_back({1'b1, 32'h40, 32'h0});
    exp_push.push_back({1'b0, 32'h44, INSTR});
    fifo_not_full = 1'b1;
    wait_push();
    wait_push();
    fifo_not_full = 1'b0;
    @(negedge clk);

    // Reset while draining: bus released next cycle, refetch at RESET_PC
    wait_adr = 32'h300;
    set_pc(32'h300);
    exp_req.push_back(32'h300); exp_req.push_back(32'h0);
    exp_push.push_back({1'b0, 32'h0, INSTR});
    fifo_not_full = 1'b1;
    wait_stb();
    redirect = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("reset_in_drain", {wb_cyc, wb_stb, push_valid, wb_adr}, {3'b000, 32'h0});
    reset = 1'b0;
    wait_push();
    fifo_not_full = 1'b0;
    @(negedge clk);

    // PC wraps modulo 2^32
    set_pc(32'hFFFF_FFFC);
    exp_req.push_back(32'hFFFF_FFFC); exp_req.push_back(32'h0);
    exp_push.push_back({1'b0, 32'hFFFF_FFFC, INSTR});
    exp_push.push_back({1'b0, 32'h0, INSTR});
    fifo_not_full = 1'b1;
    wait_push();
    wait_push();
    fifo_not_full = 1'b0;

    repeat (4) @(negedge clk);
    check("req_queue_empty", 32'(exp_req.size()), 32'd0);
    check("push_queue_empty", 32'(exp_push.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
